// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle controller that accepts one MIPS instruction per
// handshake, decodes it into ALU function/select codes and sequences
// IDLE -> DECODE -> EXEC -> WB, pulsing reg_write/branch_taken/done in WB.
// Optional build macro: CTRL_PERF_CNT_EN adds a wrapping retired-instruction
// counter on instr_count; without it instr_count is tied to zero.
module alu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        alu_zero,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic        srca_rt,
  output logic [1:0]  srcb_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wr_addr,
  output logic        reg_write,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal,
  output logic [31:0] instr_count
);

  // MIPS opcodes and R-type function fields recognised by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SLLV  = 6'b000100;

  // Internal ALU function codes.
  localparam logic [5:0] ALU_IDLE = 6'b000000;
  localparam logic [5:0] ALU_ADDU = 6'b001001;
  localparam logic [5:0] ALU_SUBU = 6'b001010;
  localparam logic [5:0] ALU_SLL  = 6'b100001;
  localparam logic [5:0] ALU_SLLV = 6'b110101;
  localparam logic [5:0] ALU_SLTI = 6'b101010;

  // Operand-B select encodings.
  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_RS  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched instruction word; pure data, so it carries no reset.
  logic [31:0] ir;
  logic        accept;

  // Instruction fields of the latched word.
  logic [5:0] f_op;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic [4:0] f_shamt;
  logic [5:0] f_funct;
  logic [15:0] f_imm;

  assign f_op    = ir[31:26];
  assign f_rs    = ir[25:21];
  assign f_rt    = ir[20:16];
  assign f_rd    = ir[15:11];
  assign f_shamt = ir[10:6];
  assign f_funct = ir[5:0];
  assign f_imm   = ir[15:0];

  // Combinational decode results of the latched word.
  logic       dec_legal;
  logic [5:0] dec_funct;
  logic [4:0] dec_shamt;
  logic       dec_srca_rt;
  logic [1:0] dec_srcb_sel;
  logic [4:0] dec_wr_addr;
  logic       dec_write;
  logic       dec_branch;

  // Next values for every registered output and internal control flag.
  logic        ready_nxt;
  logic [5:0]  funct_nxt;
  logic [4:0]  shamt_nxt;
  logic        srca_nxt;
  logic [1:0]  srcb_nxt;
  logic [31:0] imm_nxt;
  logic [4:0]  rs_nxt;
  logic [4:0]  rt_nxt;
  logic [4:0]  wr_nxt;
  logic        reg_write_nxt;
  logic        branch_nxt;
  logic        done_nxt;
  logic        illegal_nxt;

  // Per-instruction control flags captured in DECODE and consumed in EXEC.
  logic wr_en, wr_en_nxt;
  logic br_en, br_en_nxt;

  function automatic logic signed [31:0] sign_ext16(input logic [15:0] v);
    logic signed [15:0] s;
    s = $signed(v);
    return 32'(s);
  endfunction

  assign accept = (state == IDLE) && instr_valid && instr_ready;

  // Capture the instruction word on the accepting handshake.
  always_ff @(posedge clk) begin
    if (accept) ir <= instr;
  end

  // Map the latched opcode/funct onto ALU codes, operand selects and write target.
  always_comb begin
    dec_legal    = 1'b1;
    dec_funct    = ALU_IDLE;
    dec_shamt    = '0;
    dec_srca_rt  = 1'b0;
    dec_srcb_sel = SRCB_RT;
    dec_wr_addr  = '0;
    dec_write    = 1'b0;
    dec_branch   = 1'b0;
    case (f_op)
      OP_RTYPE: begin
        case (f_funct)
          FN_ADDU: begin
            dec_funct   = ALU_ADDU;
            dec_wr_addr = f_rd;
            dec_write   = 1'b1;
          end
          FN_SUBU: begin
            dec_funct   = ALU_SUBU;
            dec_wr_addr = f_rd;
            dec_write   = 1'b1;
          end
          FN_SLL: begin
            dec_funct   = ALU_SLL;
            dec_srca_rt = 1'b1;
            dec_shamt   = f_shamt;
            dec_wr_addr = f_rd;
            dec_write   = 1'b1;
          end
          FN_SLLV: begin
            dec_funct    = ALU_SLLV;
            dec_srca_rt  = 1'b1;
            dec_srcb_sel = SRCB_RS;
            dec_wr_addr  = f_rd;
            dec_write    = 1'b1;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        dec_funct    = ALU_ADDU;
        dec_srcb_sel = SRCB_IMM;
        dec_wr_addr  = f_rt;
        dec_write    = 1'b1;
      end
      OP_SLTI: begin
        dec_funct    = ALU_SLTI;
        dec_srcb_sel = SRCB_IMM;
        dec_wr_addr  = f_rt;
        dec_write    = 1'b1;
      end
      OP_BEQ: begin
        dec_funct    = ALU_SUBU;
        dec_srcb_sel = SRCB_RT;
        dec_branch   = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and next-output logic; ALU controls hold unless a state changes them.
  always_comb begin
    state_nxt     = state;
    ready_nxt     = 1'b0;
    funct_nxt     = alu_funct;
    shamt_nxt     = alu_shamt;
    srca_nxt      = srca_rt;
    srcb_nxt      = srcb_sel;
    imm_nxt       = imm;
    rs_nxt        = rs_addr;
    rt_nxt        = rt_addr;
    wr_nxt        = wr_addr;
    wr_en_nxt     = wr_en;
    br_en_nxt     = br_en;
    reg_write_nxt = 1'b0;
    branch_nxt    = 1'b0;
    done_nxt      = 1'b0;
    illegal_nxt   = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (accept) begin
          state_nxt = DECODE;
          ready_nxt = 1'b0;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          state_nxt = EXEC;
          funct_nxt = dec_funct;
          shamt_nxt = dec_shamt;
          srca_nxt  = dec_srca_rt;
          srcb_nxt  = dec_srcb_sel;
          imm_nxt   = sign_ext16(f_imm);
          rs_nxt    = f_rs;
          rt_nxt    = f_rt;
          wr_nxt    = dec_wr_addr;
          wr_en_nxt = dec_write;
          br_en_nxt = dec_branch;
        end else begin
          // Unsupported encodings skip EXEC and retire straight away as illegal.
          state_nxt   = WB;
          funct_nxt   = ALU_IDLE;
          shamt_nxt   = '0;
          srca_nxt    = 1'b0;
          srcb_nxt    = SRCB_RT;
          imm_nxt     = '0;
          rs_nxt      = '0;
          rt_nxt      = '0;
          wr_nxt      = '0;
          wr_en_nxt   = 1'b0;
          br_en_nxt   = 1'b0;
          done_nxt    = 1'b1;
          illegal_nxt = 1'b1;
        end
      end
      EXEC: begin
        // alu_zero is only looked at on this edge; later changes cannot affect the branch.
        state_nxt     = WB;
        reg_write_nxt = wr_en && (wr_addr != 5'd0);
        branch_nxt    = br_en && alu_zero;
        done_nxt      = 1'b1;
      end
      WB: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
        funct_nxt = ALU_IDLE;
        shamt_nxt = '0;
        srca_nxt  = 1'b0;
        srcb_nxt  = SRCB_RT;
        imm_nxt   = '0;
        rs_nxt    = '0;
        rt_nxt    = '0;
        wr_nxt    = '0;
        wr_en_nxt = 1'b0;
        br_en_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; an asserted reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs, all cleared while reset is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ready  <= 1'b0;
      alu_funct    <= ALU_IDLE;
      alu_shamt    <= '0;
      srca_rt      <= 1'b0;
      srcb_sel     <= SRCB_RT;
      imm          <= '0;
      rs_addr      <= '0;
      rt_addr      <= '0;
      wr_addr      <= '0;
      wr_en        <= 1'b0;
      br_en        <= 1'b0;
      reg_write    <= 1'b0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      instr_ready  <= ready_nxt;
      alu_funct    <= funct_nxt;
      alu_shamt    <= shamt_nxt;
      srca_rt      <= srca_nxt;
      srcb_sel     <= srcb_nxt;
      imm          <= imm_nxt;
      rs_addr      <= rs_nxt;
      rt_addr      <= rt_nxt;
      wr_addr      <= wr_nxt;
      wr_en        <= wr_en_nxt;
      br_en        <= br_en_nxt;
      reg_write    <= reg_write_nxt;
      branch_taken <= branch_nxt;
      done         <= done_nxt;
      illegal      <= illegal_nxt;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cnt;

  // Count legal retirements on the EXEC->WB edge, the same edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == EXEC) cnt <= cnt + 32'd1;
  end

  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: scoreboard bench for alu_ctrl_fsm. A driver issues directed
// and random instructions and pushes the expected retirement record; a
// negedge monitor pops and compares whenever done is presented.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        instr_ready;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic        srca_rt;
  logic [1:0]  srcb_sel;
  logic [31:0] imm;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wr_addr;
  logic        reg_write;
  logic        branch_taken;
  logic        done;
  logic        illegal;
  logic [31:0] instr_count;

  alu_ctrl_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .alu_zero     (alu_zero),
    .alu_funct    (alu_funct),
    .alu_shamt    (alu_shamt),
    .srca_rt      (srca_rt),
    .srcb_sel     (srcb_sel),
    .imm          (imm),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .wr_addr      (wr_addr),
    .reg_write    (reg_write),
    .branch_taken (branch_taken),
    .done         (done),
    .illegal      (illegal),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic        sa;
    logic [1:0]  sb;
    logic        chk_sb;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        chk_wr;
    logic        we;
    logic        br;
    logic        ill;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt = '0;
  int          rdy_cyc = -1;
  int          zero_cyc = -1;
  logic        zero_val = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: what each instruction should do, written from the decode table.
  function automatic exp_t model(input logic [31:0] w, input logic zp);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic signed [31:0] simm;
    op = w[31:26];
    fn = w[5:0];
    simm = $signed(w[15:0]);
    e.fn = 6'b000000; e.sh = 5'd0; e.sa = 1'b0; e.sb = 2'b00; e.chk_sb = 1'b1;
    e.imm = simm; e.rs = w[25:21]; e.rt = w[20:16]; e.wr = 5'd0; e.chk_wr = 1'b0;
    e.we = 1'b0; e.br = 1'b0; e.ill = 1'b0; e.acc = 0;
    if (op == 6'd0 && fn == 6'b100001) begin
      e.fn = 6'b001001; e.wr = w[15:11]; e.chk_wr = 1'b1;
    end else if (op == 6'd0 && fn == 6'b100011) begin
      e.fn = 6'b001010; e.wr = w[15:11]; e.chk_wr = 1'b1;
    end else if (op == 6'd0 && fn == 6'b000000) begin
      e.fn = 6'b100001; e.sa = 1'b1; e.sh = w[10:6]; e.chk_sb = 1'b0;
      e.wr = w[15:11]; e.chk_wr = 1'b1;
    end else if (op == 6'd0 && fn == 6'b000100) begin
      e.fn = 6'b110101; e.sa = 1'b1; e.sb = 2'b10; e.wr = w[15:11]; e.chk_wr = 1'b1;
    end else if (op == 6'b001001) begin
      e.fn = 6'b001001; e.sb = 2'b01; e.wr = w[20:16]; e.chk_wr = 1'b1;
    end else if (op == 6'b001010) begin
      e.fn = 6'b101010; e.sb = 2'b01; e.wr = w[20:16]; e.chk_wr = 1'b1;
    end else if (op == 6'b000100) begin
      e.fn = 6'b001010; e.sb = 2'b00; e.br = zp;
    end else begin
      e.ill = 1'b1;
    end
    e.we = e.chk_wr && (e.wr != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 8);
    case (k)
      0: begin w[31:26] = 6'd0; w[5:0] = 6'b100001; end
      1: begin w[31:26] = 6'd0; w[5:0] = 6'b100011; end
      2: begin w[31:26] = 6'd0; w[5:0] = 6'b000000; end
      3: begin w[31:26] = 6'd0; w[5:0] = 6'b000100; end
      4: w[31:26] = 6'b001001;
      5: w[31:26] = 6'b001010;
      6: w[31:26] = 6'b000100;
      7: w[31:26] = 6'd0;
      default: ;
    endcase
    if ($urandom_range(0, 5) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 5) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rdy_cyc = -1;
      exp_cnt = '0;
    end else begin
      if (!done) chk("pulse_without_done", {reg_write, branch_taken, illegal}, 3'b000);
      if (sb_q.size() != 0 && !sb_q[0].ill && cyc == sb_q[0].acc + 1) begin
        chk("exec_alu_funct", alu_funct, sb_q[0].fn);
        chk("exec_ready_low", instr_ready, 1'b0);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, expected no retirement pending (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_latency", cyc - e.acc, e.ill ? 1 : 2);
          chk("illegal", illegal, e.ill);
          chk("reg_write", reg_write, e.we);
          chk("branch_taken", branch_taken, e.br);
          chk("wb_ready_low", instr_ready, 1'b0);
          if (!e.ill) begin
            chk("alu_funct", alu_funct, e.fn);
            chk("alu_shamt", alu_shamt, e.sh);
            chk("srca_rt", srca_rt, e.sa);
            if (e.chk_sb) chk("srcb_sel", srcb_sel, e.sb);
            chk("imm", imm, e.imm);
            chk("rs_addr", rs_addr, e.rs);
            chk("rt_addr", rt_addr, e.rt);
            if (e.chk_wr) chk("wr_addr", wr_addr, e.wr);
            exp_cnt = exp_cnt + 32'd1;
          end
          rdy_cyc = cyc + 1;
        end
      end
      if (cyc == rdy_cyc) begin
        chk("ready_after_wb", instr_ready, 1'b1);
`ifdef CTRL_PERF_CNT_EN
        chk("instr_count", instr_count, exp_cnt);
`else
        chk("instr_count_tied", instr_count, 32'd0);
`endif
        rdy_cyc = -1;
      end
    end
  end

  // One negedge: drive alu_zero (planned value during a beq's EXEC) and junk while busy.
  task automatic step();
    @(negedge clk);
    alu_zero = (cyc == zero_cyc) ? zero_val : 1'($urandom_range(0, 1));
    instr    = $urandom;
    if (instr_ready) instr_valid = 1'b0;
    else             instr_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [31:0] w, input logic zp);
    exp_t e;
    int n;
    n = 0;
    step();
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    if (!instr_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got instr_ready=0, expected 1 within 20 cycles (cycle %0d)", cyc);
    end else begin
      instr_valid = 1'b1;
      instr       = w;
      e           = model(w, zp);
      e.acc       = cyc + 1;
      sb_q.push_back(e);
      if (w[31:26] == 6'b000100) begin
        zero_cyc = cyc + 2;
        zero_val = zp;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {instr_ready, alu_funct, alu_shamt, srca_rt, srcb_sel,
                         reg_write, branch_taken, done, illegal}, 64'd0);
    chk({tag, "_data"}, {imm, rs_addr, rt_addr, wr_addr}, 64'd0);
    chk({tag, "_count"}, instr_count, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    #3 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_before_first_edge", instr_ready, 1'b0);

    // Directed cases from the decode table.
    issue(32'h00221821, 1'b0);   // addu $3,$1,$2
    issue(32'h00022140, 1'b0);   // sll  $4,$2,5
    issue(32'h2425FFFC, 1'b0);   // addiu $5,$1,-4
    issue(32'h10220003, 1'b1);   // beq taken
    issue(32'h10220003, 1'b0);   // beq not taken
    issue(32'h8C000000, 1'b0);   // lw: illegal
    drain();

    // Reset while a following addu is in EXEC aborts it.
    issue(32'h00221821, 1'b0);
    step();
    step();
    #2 rst = 1'b1;
    sb_q.delete();
    zero_cyc = -1;
    #1 check_reset_outputs("abort_async");
    step();
    check_reset_outputs("abort_held");
    rst = 1'b0;
    #1 chk("abort_ready_before_edge", instr_ready, 1'b0);
    step();
    chk("abort_ready_after_edge", instr_ready, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) issue(rand_instr(), 1'($urandom_range(0, 1)));
    drain();

`ifdef CTRL_PERF_CNT_EN
    force dut.cnt = 32'hFFFF_FFFF;
    step();
    release dut.cnt;
    exp_cnt = 32'hFFFF_FFFF;
    issue(32'h00221821, 1'b0);
    drain();
    chk("count_wrap", instr_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
